ppu_cmd_fifo: RTL and testbench

- Command buffer between the processor's PPU store path (ppu_send / interface_data) and the PPU's command input (receive / ppu_data).
- Replaces the single holding register, so back-to-back PPU writes from the processor are not lost while the PPU is busy.
- Accepts 32-bit command words, stores them in order, and issues them to the PPU one at a time as single-cycle receive pulses.
- Issue is gated by the PPU's ready level and a minimum inter-command gap.

---
 rtl/ppu_cmd_fifo.sv | 97 +++++++++
 tb/tb_ppu_cmd_fifo.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_cmd_fifo.sv
// Ordered command buffer between the processor PPU store path and the PPU command input.
// Optional saturating drop counter output enabled by defining PPU_FIFO_DROP_CNT_EN.
module ppu_cmd_fifo #(
  parameter int DEPTH = 16,
  parameter int GAP   = 3,
  parameter int DW    = 32
) (
  input  logic                   sys_clk,
  input  logic                   rst_n,
  input  logic                   ppu_send,
  input  logic [DW-1:0]          interface_data,
  input  logic                   ppu_ready,
  input  logic                   clr_ovf,
  output logic                   receive,
  output logic [DW-1:0]          ppu_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
`ifdef PPU_FIFO_DROP_CNT_EN
  ,
  output logic [15:0]            drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (GAP < 1) ? 1 : $clog2(GAP + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [GW-1:0] gap_cnt;
  logic          wr_ok;
  logic          rd_fire;
  logic          drop;

  function automatic logic [GW-1:0] sat_dec(input logic [GW-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 1'b1;
  endfunction

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign rd_fire = !empty && ppu_ready && (gap_cnt == '0);
  // A full FIFO still accepts a write when a word leaves on the same edge.
  assign wr_ok   = ppu_send && (!full || rd_fire);
  assign drop    = ppu_send && full && !rd_fire;

  always_ff @(posedge sys_clk) begin
    if (wr_ok) mem[wr_ptr] <= interface_data;
  end

  // Issue stage: mem[rd_ptr] is read before any same-edge write lands there.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      gap_cnt  <= '0;
      receive  <= 1'b0;
      ppu_data <= '0;
      overflow <= 1'b0;
    end else begin
      receive <= rd_fire;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) begin
        rd_ptr   <= rd_ptr + 1'b1;
        ppu_data <= mem[rd_ptr];
        gap_cnt  <= GAP_LOAD;
      end else begin
        gap_cnt  <= sat_dec(gap_cnt);
      end
      case ({wr_ok, rd_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

`ifdef PPU_FIFO_DROP_CNT_EN
  always_ff @(posedge sys_clk) begin
    if (!rst_n)       drop_cnt <= '0;
    else if (drop)    drop_cnt <= clr_ovf ? 16'd1 : sat_inc16(drop_cnt);
    else if (clr_ovf) drop_cnt <= '0;
  end
`endif

endmodule

// File: tb/tb_ppu_cmd_fifo.sv
// Directed self-checking bench for ppu_cmd_fifo (DEPTH=16, GAP=3, DW=32).
module tb_ppu_cmd_fifo;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        ppu_send;
  logic [31:0] interface_data;
  logic        ppu_ready;
  logic        clr_ovf;
  logic        receive;
  logic [31:0] ppu_data;
  logic        full;
  logic        empty;
  logic [4:0]  count;
  logic        overflow;
`ifdef PPU_FIFO_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 sys_clk = ~sys_clk;

  ppu_cmd_fifo #(.DEPTH(16), .GAP(3), .DW(32)) dut (
    .sys_clk        (sys_clk),
    .rst_n          (rst_n),
    .ppu_send       (ppu_send),
    .interface_data (interface_data),
    .ppu_ready      (ppu_ready),
    .clr_ovf        (clr_ovf),
    .receive        (receive),
    .ppu_data       (ppu_data),
    .full           (full),
    .empty          (empty),
    .count          (count),
    .overflow       (overflow)
`ifdef PPU_FIFO_DROP_CNT_EN
    ,
    .drop_cnt       (drop_cnt)
`endif
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++; if (receive !== 1'b0) begin n_fail++; $display("FAIL rst_receive: got %b want 0", receive); end
    n_checks++; if (ppu_data !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0", ppu_data); end
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", count); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %b want 1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %b want 0", full); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b want 0", overflow); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    ppu_ready = 1'b1;
    ppu_send = 1'b1;
    interface_data = 32'hA5A5_0001;
    tick();
    ppu_send = 1'b0;
    n_checks++; if (receive !== 1'b0) begin n_fail++; $display("FAIL single_nofall: got %b want 0", receive); end
    n_checks++; if (count !== 5'd1) begin n_fail++; $display("FAIL single_cnt1: got %0d want 1", count); end
    tick();
    n_checks++; if (receive !== 1'b1) begin n_fail++; $display("FAIL single_rx: got %b want 1", receive); end
    n_checks++; if (ppu_data !== 32'hA5A5_0001) begin n_fail++; $display("FAIL single_data: got %h want a5a50001", ppu_data); end
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL single_cnt0: got %0d want 0", count); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_empty: got %b want 1", empty); end
    tick();
    n_checks++; if (receive !== 1'b0) begin n_fail++; $display("FAIL single_pulse: got %b want 0", receive); end
    n_checks++; if (ppu_data !== 32'hA5A5_0001) begin n_fail++; $display("FAIL single_hold: got %h want a5a50001", ppu_data); end
    repeat (4) tick();
  endtask

  task automatic test_burst_gap();
    int k = 0;
    int last = 0;
    int peak = 0;
    logic [31:0] exp;
    ppu_ready = 1'b1;
    for (int i = 0; i < 25; i++) begin
      ppu_send = (i < 5);
      interface_data = 32'h10 + 32'(i);
      tick();
      if (int'(count) > peak) peak = int'(count);
      if (receive) begin
        exp = 32'h10 + 32'(k);
        n_checks++; if (ppu_data !== exp) begin n_fail++; $display("FAIL burst_data%0d: got %h want %h", k, ppu_data, exp); end
        if (k > 0) begin
          n_checks++; if (i - last != 4) begin n_fail++; $display("FAIL burst_gap%0d: got %0d want 4", k, i - last); end
        end
        last = i;
        k++;
      end
    end
    ppu_send = 1'b0;
    n_checks++; if (k != 5) begin n_fail++; $display("FAIL burst_pulses: got %0d want 5", k); end
    n_checks++; if (peak != 4) begin n_fail++; $display("FAIL burst_peak: got %0d want 4", peak); end
  endtask

  task automatic test_overflow();
    int k = 0;
    logic [31:0] exp;
    ppu_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ppu_send = 1'b1;
      interface_data = 32'h100 + 32'(i);
      tick();
    end
    ppu_send = 1'b0;
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b want 1", full); end
    n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL ovf_cnt16: got %0d want 16", count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_pre: got %b want 0", overflow); end
    ppu_send = 1'b1;
    interface_data = 32'hDEAD;
    tick();
    ppu_send = 1'b0;
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", overflow); end
    n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL ovf_cnt: got %0d want 16", count); end
    ppu_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (receive) begin
        exp = 32'h100 + 32'(k);
        n_checks++; if (ppu_data !== exp) begin n_fail++; $display("FAIL ovf_drain%0d: got %h want %h", k, ppu_data, exp); end
        k++;
      end
    end
    n_checks++; if (k != 16) begin n_fail++; $display("FAIL ovf_words: got %0d want 16", k); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ovf_empty: got %b want 1", empty); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b want 0", overflow); end
  endtask

  task automatic test_full_write_issue();
    int k = 0;
    logic [31:0] exp;
    ppu_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ppu_send = 1'b1;
      interface_data = 32'h200 + 32'(i);
      tick();
    end
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fwi_full: got %b want 1", full); end
    ppu_ready = 1'b1;
    interface_data = 32'h77;
    tick();
    ppu_send = 1'b0;
    n_checks++; if (receive !== 1'b1) begin n_fail++; $display("FAIL fwi_rx: got %b want 1", receive); end
    n_checks++; if (ppu_data !== 32'h200) begin n_fail++; $display("FAIL fwi_data: got %h want 200", ppu_data); end
    n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL fwi_cnt: got %0d want 16", count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fwi_ovf: got %b want 0", overflow); end
    for (int i = 0; i < 80; i++) begin
      tick();
      if (receive) begin
        exp = (k < 15) ? 32'h201 + 32'(k) : 32'h77;
        n_checks++; if (ppu_data !== exp) begin n_fail++; $display("FAIL fwi_drain%0d: got %h want %h", k, ppu_data, exp); end
        k++;
      end
    end
    n_checks++; if (k != 16) begin n_fail++; $display("FAIL fwi_words: got %0d want 16", k); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fwi_empty: got %b want 1", empty); end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    ppu_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ppu_send = 1'b1;
      interface_data = 32'h300 + 32'(i);
      tick();
    end
    ppu_send = 1'b0;
    ppu_ready = 1'b1;
    for (int i = 0; i < 60 && k < 4; i++) begin
      tick();
      if (receive) k++;
    end
    n_checks++; if (count !== 5'd6) begin n_fail++; $display("FAIL mid_cnt6: got %0d want 6", count); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++; if (receive !== 1'b0) begin n_fail++; $display("FAIL mid_rx: got %b want 0", receive); end
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL mid_cnt: got %0d want 0", count); end
    n_checks++; if (ppu_data !== 32'h0) begin n_fail++; $display("FAIL mid_data: got %h want 0", ppu_data); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mid_ovf: got %b want 0", overflow); end
    ppu_send = 1'b1;
    interface_data = 32'h55;
    tick();
    ppu_send = 1'b0;
    tick();
    n_checks++; if (receive !== 1'b1) begin n_fail++; $display("FAIL mid_rx55: got %b want 1", receive); end
    n_checks++; if (ppu_data !== 32'h55) begin n_fail++; $display("FAIL mid_data55: got %h want 55", ppu_data); end
    repeat (6) tick();
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL mid_stale: got %0d want 0", count); end
  endtask

  task automatic test_drop_clr();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ppu_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ppu_send = 1'b1;
      interface_data = 32'h400 + 32'(i);
      tick();
    end
    interface_data = 32'hBAD;
    repeat (3) tick();
    ppu_send = 1'b0;
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL drop_ovf: got %b want 1", overflow); end
    n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL drop_cnt16: got %0d want 16", count); end
`ifdef PPU_FIFO_DROP_CNT_EN
    n_checks++; if (drop_cnt !== 16'd3) begin n_fail++; $display("FAIL drop_cnt3: got %0d want 3", drop_cnt); end
`endif
    clr_ovf = 1'b1;
    ppu_send = 1'b1;
    tick();
    clr_ovf = 1'b0;
    ppu_send = 1'b0;
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL drop_setwins: got %b want 1", overflow); end
`ifdef PPU_FIFO_DROP_CNT_EN
    n_checks++; if (drop_cnt !== 16'd1) begin n_fail++; $display("FAIL drop_cnt1: got %0d want 1", drop_cnt); end
`endif
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL drop_clr: got %b want 0", overflow); end
`ifdef PPU_FIFO_DROP_CNT_EN
    n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL drop_cnt0: got %0d want 0", drop_cnt); end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    ppu_send = 1'b0;
    interface_data = 32'h0;
    ppu_ready = 1'b0;
    clr_ovf = 1'b0;
    #2;
    test_reset();
    test_single();
    test_burst_gap();
    test_overflow();
    test_full_write_issue();
    test_reset_mid();
    test_drop_clr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
